// File: rtl/ahb2_sram_slave.sv
// AHB-Lite single-port memory slave with configurable wait states and an optional
// address-pattern preload.
module ahb2_sram_slave #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_AW         = 18,
  parameter int unsigned WAIT_CYCLES    = 0,
  parameter int unsigned INIT_WITH_ADDR = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int unsigned WORDS     = 2 ** (MEM_AW - 2);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t                r_state, w_state_nx;
  logic [3:0]            r_cnt, w_cnt_nx;
  logic [MEM_AW-3:0]     r_idx;
  logic                  r_write;
  logic [3:0]            r_lanes;
  logic [3:0]            w_lanes;
  logic                  w_accept, w_take, w_err_in, w_done, w_wr_en;
  logic [DATA_WIDTH-1:0] w_pat;
  logic                  w_unused;

  // Words are stored XORed with their preload pattern, so the all-zero power-up
  // contents read back as the address pattern without any init sequence.
  logic [DATA_WIDTH-1:0] r_mem [WORDS] = '{default: '0};

  function automatic logic [DATA_WIDTH-1:0] f_pat(input logic [MEM_AW-3:0] idx);
    logic [DATA_WIDTH-1:0] p;
    p = '0;
    if (INIT_WITH_ADDR != 0) p[MEM_AW-1:0] = {idx, 2'b00};
    return p;
  endfunction

  assign w_unused = ^{hburst, hprot, htrans[0]};
  assign w_accept = hsel & hready & htrans[1];
  assign w_take   = w_accept & hreadyout;
  assign w_err_in = (haddr[ADDR_WIDTH-1:MEM_AW] != '0) | (hsize > 3'd2) |
                    ((hsize == 3'd1) & haddr[0]) |
                    ((hsize == 3'd2) & (haddr[1:0] != 2'b00));
  assign w_done   = (r_state == S_DATA) && (r_cnt == '0);
  assign w_wr_en  = w_done & r_write & ~rst;
  assign w_pat    = f_pat(r_idx);

  always_comb begin
    w_lanes = 4'b1111;
    case (hsize[1:0])
      2'b00:   w_lanes = 4'b0001 << haddr[1:0];
      2'b01:   w_lanes = haddr[1] ? 4'b1100 : 4'b0011;
      default: w_lanes = 4'b1111;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    hreadyout  = 1'b1;
    hresp      = 1'b0;
    case (r_state)
      S_DATA: if (r_cnt != '0) begin
        hreadyout = 1'b0;
        w_cnt_nx  = r_cnt - 4'd1;
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      S_ERR2:  hresp = 1'b1;
      default: ;
    endcase
    if (r_state == S_ERR1) begin
      w_state_nx = S_ERR2;
    end else if (hreadyout) begin
      if (w_accept) begin
        w_state_nx = w_err_in ? S_ERR1 : S_DATA;
        w_cnt_nx   = w_err_in ? 4'd0 : WAIT_INIT;
      end else begin
        w_state_nx = S_IDLE;
      end
    end
  end

  always_comb begin
    hrdata = '0;
    if (w_done && !r_write) hrdata = r_mem[r_idx] ^ w_pat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_lanes <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_take) begin
        r_idx   <= haddr[MEM_AW-1:2];
        r_write <= hwrite;
        r_lanes <= w_lanes;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (r_lanes[k]) r_mem[r_idx][8*k +: 8] <= hwdata[8*k +: 8] ^ w_pat[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb2_sram_slave.sv
// Directed bench: one zero-wait and one two-wait slave on a shared master, selected by sel.
module tb_ahb2_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        hsel_m;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hro0, hro1, hresp0, hresp1;
  logic [31:0] hrdata0, hrdata1;
  logic        bus_hready, bus_hresp;
  logic [31:0] bus_hrdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign bus_hready = sel ? hro1    : hro0;
  assign bus_hresp  = sel ? hresp1  : hresp0;
  assign bus_hrdata = sel ? hrdata1 : hrdata0;

  ahb2_sram_slave #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .hsel(hsel_m & ~sel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hready(bus_hready), .hreadyout(hro0), .hresp(hresp0), .hrdata(hrdata0));

  ahb2_sram_slave #(.WAIT_CYCLES(2)) u_dut1 (
    .clk(clk), .rst(rst), .hsel(hsel_m & sel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hready(bus_hready), .hreadyout(hro1), .hresp(hresp1), .hrdata(hrdata1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single non-pipelined transfer; entered just after a rising edge with the bus idle.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rdat, output logic rsp,
                      output logic rsp_first, output int waits);
    logic ok;
    int   c;
    ok = 1'b0; waits = 0; rsp_first = 1'b0; c = 0;
    hsel_m = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz; hburst = 3'b000;
    @(posedge clk); #1;
    hsel_m = 1'b0; htrans = 2'b00; hwdata = wd;
    while (!ok && c < 32) begin
      @(negedge clk);
      if (bus_hready) ok = 1'b1;
      else begin
        if (waits == 0) rsp_first = bus_hresp;
        waits++;
      end
      c++;
    end
    rdat = bus_hrdata;
    rsp  = bus_hresp;
    chk("xfer_timeout", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
  endtask

  // Pipelined INCR4 word burst; lows counts data-phase cycles with hready low.
  task automatic burst4(input logic wr, input logic [31:0] base, input logic [3:0][31:0] wd,
                        output logic [3:0][31:0] rd, output int lows);
    logic ok;
    int   c;
    lows = 0;
    rd   = '0;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        hsel_m = 1'b1; htrans = (i == 0) ? 2'b10 : 2'b11; haddr = base + 32'(4 * i);
        hwrite = wr; hsize = 3'b010; hburst = 3'b011;
      end else begin
        hsel_m = 1'b0; htrans = 2'b00;
      end
      if (i > 0) hwdata = wd[i-1];
      ok = 1'b0; c = 0;
      while (!ok && c < 32) begin
        @(negedge clk);
        if (bus_hready) ok = 1'b1;
        else lows++;
        c++;
      end
      if (!ok) chk("burst_timeout", {31'd0, ok}, 32'd1);
      if (i > 0) rd[i-1] = bus_hrdata;
      @(posedge clk); #1;
    end
  endtask

  task automatic copy_and_verify(input int w);
    logic [3:0][31:0] d, r, zero;
    int lows, bad_src, bad_low, bad_dst;
    bad_src = 0; bad_low = 0; bad_dst = 0; zero = '0;
    for (int b = 0; b < 256; b++) begin
      burst4(1'b0, 32'h0001_0000 + 32'(16 * b), zero, d, lows);
      for (int k = 0; k < 4; k++)
        if (d[k] !== 32'h0001_0000 + 32'(16 * b + 4 * k)) bad_src++;
      if (lows != 4 * w) bad_low++;
      burst4(1'b1, 32'h0002_0000 + 32'(16 * b), d, r, lows);
      if (lows != 4 * w) bad_low++;
    end
    for (int b = 0; b < 256; b++) begin
      burst4(1'b0, 32'h0002_0000 + 32'(16 * b), zero, r, lows);
      for (int k = 0; k < 4; k++)
        if (r[k] !== 32'h0001_0000 + 32'(16 * b + 4 * k)) bad_dst++;
    end
    chk($sformatf("copy_src_w%0d", w), 32'(bad_src), 32'd0);
    chk($sformatf("copy_lows_w%0d", w), 32'(bad_low), 32'd0);
    chk($sformatf("copy_dst_w%0d", w), 32'(bad_dst), 32'd0);
  endtask

  initial begin
    logic [31:0] rdat;
    logic        rsp, rsp1;
    int          waits;

    rst = 1'b1; sel = 1'b0; hsel_m = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'b010; hburst = 3'b000; hprot = 4'b0011; hwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hready0", {31'd0, hro0}, 32'd1);
    chk("rst_hresp0", {31'd0, hresp0}, 32'd0);
    chk("rst_hrdata0", hrdata0, 32'd0);
    chk("rst_hready1", {31'd0, hro1}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    xfer(1'b0, 32'h0001_0000, 3'b010, '0, rdat, rsp, rsp1, waits);
    chk("pre_10000", rdat, 32'h0001_0000);
    chk("pre_10000_resp", {31'd0, rsp}, 32'd0);
    chk("pre_10000_waits", 32'(waits), 32'd0);
    xfer(1'b0, 32'h0001_0FFC, 3'b010, '0, rdat, rsp, rsp1, waits);
    chk("pre_10FFC", rdat, 32'h0001_0FFC);

    xfer(1'b1, 32'h0002_0000, 3'b010, 32'hDEAD_BEEF, rdat, rsp, rsp1, waits);
    chk("wr_word_resp", {31'd0, rsp}, 32'd0);
    xfer(1'b0, 32'h0002_0000, 3'b010, '0, rdat, rsp, rsp1, waits);
    chk("rd_deadbeef", rdat, 32'hDEAD_BEEF);
    xfer(1'b0, 32'h0002_0004, 3'b010, '0, rdat, rsp, rsp1, waits);
    chk("neighbor_20004", rdat, 32'h0002_0004);

    xfer(1'b1, 32'h0002_0011, 3'b000, 32'h5555_AA55, rdat, rsp, rsp1, waits);
    xfer(1'b0, 32'h0002_0010, 3'b010, '0, rdat, rsp, rsp1, waits);
    chk("byte_lane1", rdat, 32'h0002_AA10);
    xfer(1'b1, 32'h0002_0022, 3'b001, 32'hBEEF_1234, rdat, rsp, rsp1, waits);
    xfer(1'b0, 32'h0002_0020, 3'b010, '0, rdat, rsp, rsp1, waits);
    chk("half_upper", rdat, 32'hBEEF_0020);

    xfer(1'b0, 32'h0004_0000, 3'b010, '0, rdat, rsp, rsp1, waits);
    chk("oor_resp1", {31'd0, rsp1}, 32'd1);
    chk("oor_waits", 32'(waits), 32'd1);
    chk("oor_resp2", {31'd0, rsp}, 32'd1);
    chk("oor_rdata", rdat, 32'd0);
    xfer(1'b0, 32'h0001_0002, 3'b010, '0, rdat, rsp, rsp1, waits);
    chk("misal_resp1", {31'd0, rsp1}, 32'd1);
    chk("misal_resp2", {31'd0, rsp}, 32'd1);
    chk("misal_waits", 32'(waits), 32'd1);
    chk("misal_rdata", rdat, 32'd0);
    xfer(1'b1, 32'h0002_0030, 3'b011, 32'h1111_1111, rdat, rsp, rsp1, waits);
    chk("bigsize_resp", {31'd0, rsp}, 32'd1);
    xfer(1'b1, 32'h0002_0031, 3'b001, 32'h2222_2222, rdat, rsp, rsp1, waits);
    chk("half_misal_resp", {31'd0, rsp}, 32'd1);
    xfer(1'b0, 32'h0002_0030, 3'b010, '0, rdat, rsp, rsp1, waits);
    chk("err_no_write", rdat, 32'h0002_0030);
    chk("after_err_ok", {31'd0, rsp}, 32'd0);

    copy_and_verify(0);

    sel = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, 32'h0001_0040, 3'b010, '0, rdat, rsp, rsp1, waits);
    chk("w2_read", rdat, 32'h0001_0040);
    chk("w2_waits", 32'(waits), 32'd2);
    xfer(1'b0, 32'h0004_0000, 3'b010, '0, rdat, rsp, rsp1, waits);
    chk("w2_err_waits", 32'(waits), 32'd1);
    chk("w2_err_resp", {31'd0, rsp}, 32'd1);

    copy_and_verify(2);

    // Reset during the first wait state of a write to 0x0002_0100.
    hsel_m = 1'b1; htrans = 2'b10; haddr = 32'h0002_0100; hwrite = 1'b1; hsize = 3'b010;
    @(posedge clk); #1;
    hsel_m = 1'b0; htrans = 2'b00; hwdata = 32'h1234_5678;
    @(negedge clk);
    chk("rstmid_wait", {31'd0, hro1}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rstmid_hready", {31'd0, hro1}, 32'd1);
    chk("rstmid_hresp", {31'd0, hresp1}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rstmid_idle", {31'd0, hro1}, 32'd1);
    xfer(1'b0, 32'h0002_0100, 3'b010, '0, rdat, rsp, rsp1, waits);
    chk("rstmid_unchanged", rdat, 32'h0001_0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
